// File: rtl/imem_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : imem_loader_if
// Description : Bundle of the boot loader's control, byte-stream and
//               instruction-memory write signals.
//                 start       session request (one cycle)
//                 rx_valid    byte available on rx_data
//                 rx_data     image byte
//                 rx_ready    loader accepts a byte this cycle
//                 imem_we     one-cycle word write strobe
//                 imem_addr   word-aligned byte address of the write
//                 imem_wdata  word to write
//                 cpu_rst_n   active-low core reset
//                 busy/done/err  session status
//               master: the loader side. slave: byte source / memory / host.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_rst_n, busy, done, err
    );

    modport slave (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_rst_n, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : imem_loader
// Description : Byte-serial boot loader. Receives an image
//               (count lo, count hi, N little-endian words, XOR checksum),
//               writes the words to consecutive instruction-memory addresses
//               starting at BASE_ADDR and releases the core reset only when
//               the checksum over the data bytes matches.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - imem_loader_if.master (start, rx_* stream,
//                        imem_* write port, cpu_rst_n, busy, done, err)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          BOOT_BYPASS = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    imem_loader_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam state_t      C_RESET_STATE = BOOT_BYPASS ? S_DONE : S_IDLE;
    // Capacity in words; 33 bits so the compare stays valid for any ADDR_W.
    localparam logic [32:0] C_DEPTH       = 33'(1) << ADDR_W;

    state_t      state_q,      state_d;
    logic [15:0] count_q,      count_d;
    logic [15:0] word_idx_q,   word_idx_d;
    logic [1:0]  byte_idx_q,   byte_idx_d;
    logic [31:0] word_q,       word_d;
    logic [7:0]  xor_q,        xor_d;
    logic [31:0] imem_addr_q,  imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;

    logic        rx_ready_w;
    logic        handshake_w;
    logic [31:0] lane_word_w;
    logic [15:0] count_full_w;
    logic [15:0] word_idx_inc_w;

    // Status and strobes decode straight from the state register, so no
    // input ever reaches an output combinationally.
    assign rx_ready_w    = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                           (state_q == S_DATA) || (state_q == S_CSUM);
    assign handshake_w   = bus.rx_valid && rx_ready_w;

    assign bus.rx_ready   = rx_ready_w;
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst_n  = (state_q == S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.busy       = rx_ready_w || (state_q == S_WRITE);

    always_comb begin
        lane_word_w = word_q;
        lane_word_w[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
    end

    assign count_full_w   = {bus.rx_data, count_q[7:0]};
    assign word_idx_inc_w = word_idx_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        xor_d        = xor_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d    = S_HDR0;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                    xor_d      = 8'd0;
                end
            end

            S_HDR0: begin
                if (handshake_w) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = S_HDR1;
                end
            end

            S_HDR1: begin
                if (handshake_w) begin
                    count_d = count_full_w;
                    if ({17'd0, count_full_w} > C_DEPTH) begin
                        state_d = S_ERR;
                    end else if (count_full_w == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (handshake_w) begin
                    word_d     = lane_word_w;
                    xor_d      = xor_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // The write port is loaded on the final byte so that the
                    // address and data are already stable during WRITE.
                    if (byte_idx_q == 2'd3) begin
                        state_d      = S_WRITE;
                        imem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        imem_wdata_d = lane_word_w;
                    end
                end
            end

            S_WRITE: begin
                word_idx_d = word_idx_inc_w;
                if (word_idx_inc_w == count_q) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_CSUM: begin
                if (handshake_w) begin
                    state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERR;
                end
            end

            default: begin
                state_d = C_RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_RESET_STATE;
            count_q      <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            xor_q        <= 8'd0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            xor_q        <= xor_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A main instance
//               (ADDR_W=4, non-zero base) is exercised with directed and
//               random images against a byte-level image model; a second
//               instance covers BOOT_BYPASS=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          C_ADDR_W = 4;
    localparam int          C_DEPTH  = 1 << C_ADDR_W;
    localparam logic [31:0] C_BASE   = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if bif ();
    imem_loader_if pif ();

    imem_loader #(
        .ADDR_W(C_ADDR_W), .BASE_ADDR(C_BASE), .BOOT_BYPASS(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif.master)
    );

    imem_loader #(
        .ADDR_W(10), .BASE_ADDR(32'h0000_0000), .BOOT_BYPASS(1'b1)
    ) u_byp (
        .clk(clk), .rst_n(rst_n), .bus(pif.master)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int waits;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    bit          exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bif.imem_we === 1'b1) wr_q.push_back({bif.imem_addr, bif.imem_wdata});
    end

    // Image model: derives expected writes and outcome from the byte format.
    task automatic model(input logic [7:0] img[$]);
        int   n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        n = {img[1], img[0]};
        if (n > C_DEPTH) begin
            exp_err = 1'b1;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                w = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    w = w | (32'(img[2 + 4*i + b]) << (8*b));
                    x = x ^ img[2 + 4*i + b];
                end
                exp_q.push_back({C_BASE + 32'(4*i), w});
            end
            exp_err = (img[2 + 4*n] != x);
        end
    endtask

    task automatic compare_writes(input string name);
        check($sformatf("%s_nwr", name), 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), wr_q[i], exp_q[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            bif.rx_valid = 1'b0;
            @(negedge clk);
            waits++;
        end
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        t = 0;
        while (bif.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
            waits++;
        end
        if (t >= 50) check("rx_ready_timeout", 64'(bif.rx_ready), 64'd1);
        @(negedge clk);
        waits++;
    endtask

    task automatic start_pulse();
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [7:0] img[$],
                                 input int gap_max, input bit check_tp);
        wr_q.delete();
        model(img);
        start_pulse();
        check({name, "_rdy"},  64'(bif.rx_ready),  64'd1);
        check({name, "_busy"}, 64'(bif.busy),      64'd1);
        check({name, "_crst"}, 64'(bif.cpu_rst_n), 64'd0);
        check({name, "_err0"}, 64'(bif.err),       64'd0);
        waits = 0;
        foreach (img[i]) send_byte(img[i], gap_max);
        bif.rx_valid = 1'b0;
        compare_writes(name);
        check({name, "_done"}, 64'(bif.done),      64'(!exp_err));
        check({name, "_cpu"},  64'(bif.cpu_rst_n), 64'(!exp_err));
        check({name, "_err"},  64'(bif.err),       64'(exp_err));
        check({name, "_idle"}, 64'(bif.busy),      64'd0);
        if (check_tp) check({name, "_cycles"}, 64'(waits), 64'(img.size() + exp_q.size()));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   64'(bif.rx_ready),  64'd0);
        check({tag, "_we"},    64'(bif.imem_we),   64'd0);
        check({tag, "_addr"},  64'(bif.imem_addr), 64'(C_BASE));
        check({tag, "_wdata"}, 64'(bif.imem_wdata), 64'd0);
        check({tag, "_cpu"},   64'(bif.cpu_rst_n), 64'd0);
        check({tag, "_busy"},  64'(bif.busy),      64'd0);
        check({tag, "_done"},  64'(bif.done),      64'd0);
        check({tag, "_err"},   64'(bif.err),       64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] img[$];
        logic [7:0] normal[$];
        logic [7:0] x;
        int n;

        rst_n = 1'b0;
        bif.start = 1'b0; bif.rx_valid = 1'b0; bif.rx_data = 8'h00;
        pif.start = 1'b0; pif.rx_valid = 1'b0; pif.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Bypass instance: running straight out of reset, start re-enters load.
        check("byp_cpu",  64'(pif.cpu_rst_n), 64'd1);
        check("byp_done", 64'(pif.done),      64'd1);
        check("byp_busy", 64'(pif.busy),      64'd0);
        check("byp_rdy",  64'(pif.rx_ready),  64'd0);
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        check("byp_start_cpu",  64'(pif.cpu_rst_n), 64'd0);
        check("byp_start_busy", 64'(pif.busy),      64'd1);
        check("byp_start_rdy",  64'(pif.rx_ready),  64'd1);

        // Normal 2-word load, no gaps.
        normal = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                  8'h6F, 8'h00, 8'h00, 8'h00, 8'hD9};
        run_and_check("normal", normal, 0, 1'b1);

        // Checksum mismatch, then restart out of ERR with an empty image.
        img = normal;
        img[10] = 8'hD8;
        run_and_check("badsum", img, 0, 1'b1);
        run_and_check("zero", {8'h00, 8'h00, 8'h00}, 0, 1'b1);

        // Count beyond capacity: error right after the header.
        run_and_check("over", {8'(C_DEPTH + 1), 8'h00}, 0, 1'b1);

        // Count exactly at capacity.
        img = {8'(C_DEPTH), 8'h00};
        x = 8'h00;
        for (int i = 0; i < 4 * C_DEPTH; i++) begin
            img.push_back(8'($urandom));
            x = x ^ img[$];
        end
        img.push_back(x);
        run_and_check("full", img, 0, 1'b1);
        if (wr_q.size() > 0)
            check("full_last_addr", 64'(wr_q[wr_q.size()-1][63:32]), 64'(C_BASE + 32'(4 * (C_DEPTH - 1))));

        // Gaps on rx_valid, then random images with occasional bad checksums.
        run_and_check("gaps", normal, 3, 1'b0);
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(5, 1));
            img = {8'(n), 8'h00};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                img.push_back(8'($urandom));
                x = x ^ img[$];
            end
            if ($urandom_range(2, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
            img.push_back(x);
            run_and_check($sformatf("rnd%0d", r), img, 3, 1'b0);
        end

        // Start pulsed mid-DATA has no effect.
        wr_q.delete();
        model(normal);
        start_pulse();
        for (int i = 0; i < 4; i++) send_byte(normal[i], 0);
        bif.rx_valid = 1'b0;
        start_pulse();
        check("ign_busy", 64'(bif.busy), 64'd1);
        for (int i = 4; i < normal.size(); i++) send_byte(normal[i], 0);
        bif.rx_valid = 1'b0;
        compare_writes("ign");
        check("ign_done", 64'(bif.done), 64'd1);

        // Reset in the middle of a word.
        wr_q.delete();
        start_pulse();
        for (int i = 0; i < 4; i++) send_byte(normal[i], 0);
        bif.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        check("async_rst_byp", 64'(pif.done), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_nwr", 64'(wr_q.size()), 64'd0);
        run_and_check("after_rst", normal, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Byte-serial boot loader that writes a program image into instruction memory and holds the CPU core in reset until the image is complete and verified. It sits between an external byte source (UART receiver or testbench) and the instruction-memory write port, and drives the core's `rst_n`. It assembles little-endian words and writes them at consecutive word addresses. It checks an XOR checksum and releases the core only on a match.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word-aligned.
- `BOOT_BYPASS`, default 0: if 1, reset lands in DONE with the core running.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load session.
- `rx_valid`  in  1  source has a byte on `rx_data`.
- `rx_data`  in  8  image byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; transfer occurs when `rx_valid && rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the write, word-aligned.
- `imem_wdata`  out  32  word to write.
- `cpu_rst_n`  out  1  active-low reset to the core.
- `busy`  out  1  session in progress.
- `done`  out  1  image loaded and verified; core running.
- `err`  out  1  session failed; core held in reset.

## Operation
- Image format, in byte order: count low byte, count high byte (16-bit word count N), N×4 data bytes (each word little-endian, LSB first), then 1 checksum byte. The checksum is the XOR of all data bytes only; header bytes are excluded.
- States: IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: `start` goes to HDR0.
- HDR0: on a handshake, latch the count low byte, then go to HDR1.
- HDR1: on a handshake, latch the count high byte.
  - N > DEPTH: go to ERR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: on each handshake, shift the byte into the word register at byte lane `byte_idx`. On the 4th byte, go to WRITE.
- WRITE: `imem_we` is 1 for exactly this cycle, with `imem_addr` = BASE_ADDR + 4×word_idx.
  - Then increment `word_idx`.
  - If `word_idx` reaches N, go to CSUM; otherwise go back to DATA.
- CSUM: on a handshake, compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
- DONE and ERR: `start` restarts the session at HDR0 and clears the byte/word indices and the running XOR.
- `start` is ignored in HDR0, HDR1, DATA, WRITE and CSUM.
- `rx_ready` = 1 exactly in HDR0, HDR1, DATA and CSUM. It is 0 in IDLE, WRITE, DONE and ERR.
- `cpu_rst_n` = 1 only in DONE. `busy` = 1 in HDR0 through CSUM. `done` = 1 in DONE. `err` = 1 in ERR.
- `imem_addr` and `imem_wdata` hold their last value when `imem_we` = 0.
- Arithmetic:
  - `word_idx` is 16 bits.
  - The address is computed as BASE_ADDR + {word_idx, 2'b00}, truncated to 32 bits.
  - The running XOR is 8 bits and starts at 0 per session.
- Words already written before an error or reset stay in memory; the loader does not erase them.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Reset values:
  - state: IDLE, or DONE if BOOT_BYPASS = 1.
  - `rx_ready` 0, `imem_we` 0, `imem_addr` BASE_ADDR, `imem_wdata` 0.
  - `cpu_rst_n` = BOOT_BYPASS, `busy` 0, `done` = BOOT_BYPASS, `err` 0.
- `start` at edge k puts the loader in HDR0 from cycle k+1: `rx_ready` = 1 and `busy` = 1.
- If `start` comes from DONE, `cpu_rst_n` falls in cycle k+1.
- The 4th data byte accepted at edge k gives `imem_we` = 1 during cycle k+1; `rx_ready` returns to 1 in cycle k+2.
- Sustained throughput is 4 bytes per 5 cycles.
- A checksum byte accepted at edge k gives `cpu_rst_n`/`done` (match) or `err` (mismatch) in cycle k+1.
- Gaps in `rx_valid` stall the loader with no state change. A byte with `rx_valid` = 1 while `rx_ready` = 0 is not consumed; the source must hold it.
- Asserting `rst_n` mid-session immediately returns to reset values and discards any partial word. No write is issued for the partial word.

## Test plan
- Normal load, 2 words: bytes 02 00 13 05 A0 00 6F 00 00 00 D9 -> writes (0x0, 0x00A00513) then (0x4, 0x0000006F), one cycle each. Then `done` = 1 and `cpu_rst_n` = 1 the cycle after D9.
- Checksum mismatch: same image with final byte D8 -> both writes occur; `err` = 1 and `cpu_rst_n` stays 0. A following `start` reaches HDR0 with `err` = 0.
- Boundaries:
  - Count 00 00 then checksum 00 -> no `imem_we`; DONE.
  - Count DEPTH+1 -> ERR right after the second header byte; no writes.
  - Count = DEPTH -> the last write is at address BASE_ADDR + 4×(DEPTH−1).
- Back-pressure and gaps: random `rx_valid` gaps, with `rx_valid` held during the WRITE cycle -> identical writes to the normal case; no byte lost or duplicated.
- Reset mid-word: after 2 of 4 data bytes, pulse `rst_n` low -> all outputs take reset values asynchronously and no `imem_we` pulse occurs. A new session then loads correctly from BASE_ADDR.
- Start ignored and bypass:
  - `start` pulsed in DATA -> no effect.
  - BOOT_BYPASS = 1 -> `cpu_rst_n` = 1 and `done` = 1 directly out of reset.
  - In bypass, `start` drops `cpu_rst_n` the next cycle.
